// File: rtl/component_pkg.sv
// Shared types, index constants and block-count helper for the slice component scheduler.
package component_pkg;

   localparam int unsigned DEFAULT_SIZE_W = 16;
   localparam int unsigned COUNT_W        = 32;
   localparam int unsigned INDEX_W        = 2;

   localparam logic [INDEX_W-1:0] COMP_Y  = 2'd0;
   localparam logic [INDEX_W-1:0] COMP_CB = 2'd1;
   localparam logic [INDEX_W-1:0] COMP_CR = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_RUN    = 3'd2,
      ST_NEXT   = 3'd3,
      ST_DONE   = 3'd4
   } sched_state_e;

   // Slice configuration captured on an accepted slice_start.
   typedef struct packed {
      logic [COUNT_W-1:0] luma_blocks;
      logic               chroma_422;
   } slice_cfg_t;

   // Block count for a component: luma as-is, chroma halved in 4:2:2.
   function automatic logic [COUNT_W-1:0] comp_blocks(input logic [INDEX_W-1:0] idx,
                                                       input slice_cfg_t          cfg);
      if (idx == COMP_Y) begin
         return cfg.luma_blocks;
      end
      return cfg.chroma_422 ? (cfg.luma_blocks >> 1) : cfg.luma_blocks;
   endfunction

endpackage

// File: rtl/slice_sched_watchdog.sv
// RUN-state watchdog: counts consecutive RUN cycles, flags when the limit is hit.
module slice_sched_watchdog #(
   parameter int unsigned WATCHDOG_CYCLES = 4096
) (
   input  logic clock,
   input  logic reset_n,
   input  logic run,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(WATCHDOG_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   // Counter clears whenever the scheduler is outside RUN, saturates at the limit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (!run) begin
         cnt_q <= '0;
      end else if (!expired_c) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Expires on the WATCHDOG_CYCLES-th RUN cycle.
   assign expired_c = run && (cnt_q == CNT_W'(WATCHDOG_CYCLES - 1));

endmodule

// File: rtl/slice_component_scheduler.sv
// Slice-level sequencer for the Y/Cb/Cr component encode pipeline.
// Optional RUN watchdog enabled by defining SLICE_SCHED_WATCHDOG_EN.
module slice_component_scheduler
   import component_pkg::*;
#(
   parameter int unsigned RESET_CYCLES    = 2,
   parameter int unsigned SIZE_W          = DEFAULT_SIZE_W,
   parameter int unsigned WATCHDOG_CYCLES = 4096
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                slice_start,
   input  logic [COUNT_W-1:0]  slice_block_num,
   input  logic                chroma_422,
   input  logic                comp_done,
   input  logic [COUNT_W-1:0]  comp_byte_count,
   output logic                busy,
   output logic                comp_reset_n,
   output logic [INDEX_W-1:0]  comp_index,
   output logic [COUNT_W-1:0]  comp_block_num,
   output logic [SIZE_W-1:0]   y_size,
   output logic [SIZE_W-1:0]   cb_size,
   output logic [SIZE_W-1:0]   cr_size,
   output logic [COUNT_W-1:0]  slice_size,
   output logic                size_overflow,
   output logic                slice_done,
   output logic                timeout_err
);

   localparam int unsigned RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RCNT_W-1:0]  RCNT_LOAD = RCNT_W'(RESET_CYCLES - 1);
   localparam logic [COUNT_W-1:0] SIZE_MAX  = COUNT_W'((64'd1 << SIZE_W) - 64'd1);

   sched_state_e       state_q, state_d;
   slice_cfg_t         cfg_q, cfg_d;
   logic [RCNT_W-1:0]  rcnt_q, rcnt_d;

   logic               busy_d;
   logic               comp_reset_n_d;
   logic [INDEX_W-1:0] comp_index_d;
   logic [COUNT_W-1:0] comp_block_num_d;
   logic [SIZE_W-1:0]  y_size_d, cb_size_d, cr_size_d;
   logic [COUNT_W-1:0] slice_size_d;
   logic               size_overflow_d;
   logic               slice_done_d;
   logic               timeout_err_d;

   logic               wr_en;
   logic [INDEX_W-1:0] wr_idx;
   logic [SIZE_W-1:0]  wr_val;
   logic               count_over;
   logic [INDEX_W-1:0] nxt_idx;
   logic [COUNT_W-1:0] nxt_blocks;
   logic               wd_expired_c;

`ifdef SLICE_SCHED_WATCHDOG_EN
   slice_sched_watchdog #(
      .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
   ) u_watchdog (
      .clock     (clock),
      .reset_n   (reset_n),
      .run       (state_q == ST_RUN),
      .expired_c (wd_expired_c)
   );
`else
   // Watchdog compiled out: never expires.
   assign wd_expired_c = 1'b0 && (WATCHDOG_CYCLES == 0);
`endif

   // State and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         cfg_q          <= '0;
         rcnt_q         <= '0;
         busy           <= 1'b0;
         comp_reset_n   <= 1'b0;
         comp_index     <= COMP_Y;
         comp_block_num <= '0;
         y_size         <= '0;
         cb_size        <= '0;
         cr_size        <= '0;
         slice_size     <= '0;
         size_overflow  <= 1'b0;
         slice_done     <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cfg_q          <= cfg_d;
         rcnt_q         <= rcnt_d;
         busy           <= busy_d;
         comp_reset_n   <= comp_reset_n_d;
         comp_index     <= comp_index_d;
         comp_block_num <= comp_block_num_d;
         y_size         <= y_size_d;
         cb_size        <= cb_size_d;
         cr_size        <= cr_size_d;
         slice_size     <= slice_size_d;
         size_overflow  <= size_overflow_d;
         slice_done     <= slice_done_d;
         timeout_err    <= timeout_err_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d          = state_q;
      cfg_d            = cfg_q;
      rcnt_d           = rcnt_q;
      busy_d           = busy;
      comp_index_d     = comp_index;
      comp_block_num_d = comp_block_num;
      y_size_d         = y_size;
      cb_size_d        = cb_size;
      cr_size_d        = cr_size;
      slice_size_d     = slice_size;
      size_overflow_d  = size_overflow;
      timeout_err_d    = timeout_err;
      slice_done_d     = 1'b0;
      comp_reset_n_d   = 1'b0;
      wr_en            = 1'b0;
      wr_idx           = comp_index;
      wr_val           = '0;
      count_over       = comp_byte_count > SIZE_MAX;
      nxt_idx          = comp_index + INDEX_W'(1);
      nxt_blocks       = comp_blocks(nxt_idx, cfg_q);

      case (state_q)
         ST_IDLE: begin
            if (slice_start) begin
               cfg_d.luma_blocks = slice_block_num;
               cfg_d.chroma_422  = chroma_422;
               y_size_d          = '0;
               cb_size_d         = '0;
               cr_size_d         = '0;
               slice_size_d      = '0;
               size_overflow_d   = 1'b0;
               timeout_err_d     = 1'b0;
               comp_index_d      = COMP_Y;
               comp_block_num_d  = slice_block_num;
               rcnt_d            = RCNT_LOAD;
               busy_d            = 1'b1;
               state_d           = (slice_block_num == '0) ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (rcnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               rcnt_d = rcnt_q - RCNT_W'(1);
            end
         end
         ST_RUN: begin
            if (comp_done) begin
               wr_en           = 1'b1;
               wr_val          = count_over ? '1 : comp_byte_count[SIZE_W-1:0];
               size_overflow_d = size_overflow | count_over;
               state_d         = ST_NEXT;
            end else if (wd_expired_c) begin
               wr_en         = 1'b1;
               timeout_err_d = 1'b1;
               state_d       = ST_DONE;
            end
         end
         ST_NEXT: begin
            if (comp_index == COMP_CR) begin
               state_d = ST_DONE;
            end else begin
               comp_index_d     = nxt_idx;
               comp_block_num_d = nxt_blocks;
               rcnt_d           = RCNT_LOAD;
               if (nxt_blocks == '0) begin
                  // Empty component: record size 0 and move on without a launch.
                  wr_en   = 1'b1;
                  wr_idx  = nxt_idx;
                  state_d = ST_NEXT;
               end else begin
                  state_d = ST_LAUNCH;
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (wr_en) begin
         case (wr_idx)
            COMP_Y:  y_size_d  = wr_val;
            COMP_CB: cb_size_d = wr_val;
            default: cr_size_d = wr_val;
         endcase
      end

      // Pipeline runs only in RUN; slice total and pulse land with DONE.
      comp_reset_n_d = (state_d == ST_RUN);
      if (state_d == ST_DONE) begin
         slice_done_d = 1'b1;
         slice_size_d = COUNT_W'(y_size_d) + COUNT_W'(cb_size_d) + COUNT_W'(cr_size_d);
      end
   end

endmodule

// File: doc/slice_component_scheduler.md
Name: slice_component_scheduler

Overview:
- Slice-level controller that sequences the per-component encode pipeline (DCT → DC VLC → AC VLC) through the Y, Cb and Cr components of one slice.
- For each component it restarts the component pipeline via a reset pulse and supplies that component's block count.
- It waits for the pipeline's completion, then latches the byte size the pipeline reports.
- When all three components are done it reports per-component sizes and the total slice size to the slice-header writer.

Parameters:
- RESET_CYCLES, 2: number of cycles comp_reset_n is held low per component launch (minimum 1).
- SIZE_W, 16: width of each per-component size output.
- WATCHDOG_CYCLES, 4096: RUN-state timeout in cycles; used only when SLICE_SCHED_WATCHDOG_EN is defined.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- slice_start  input  1  single-cycle pulse that begins a slice; sampled only in IDLE.
- slice_block_num  input  32  luma blocks per slice; latched on the accepted slice_start.
- chroma_422  input  1  1 = 4:2:2 (chroma blocks = luma/2), 0 = 4:4:4; latched with slice_block_num.
- comp_done  input  1  component pipeline finished (AC flush complete); sampled only in RUN.
- comp_byte_count  input  32  bytes produced by the current component; valid while comp_done = 1.
- busy  output  1  high from the cycle after an accepted slice_start until the cycle after slice_done.
- comp_reset_n  output  1  active-low restart for the component pipeline.
- comp_index  output  2  current component: 0 = Y, 1 = Cb, 2 = Cr.
- comp_block_num  output  32  block count for the current component; stable while comp_reset_n = 1.
- y_size, cb_size, cr_size  output  SIZE_W each  latched component byte sizes.
- slice_size  output  32  y_size + cb_size + cr_size.
- size_overflow  output  1  sticky per slice; set if any comp_byte_count exceeds 2^SIZE_W − 1.
- slice_done  output  1  single-cycle completion pulse.
- timeout_err  output  1  watchdog error; tied to 0 when the optional feature is compiled out.

Behaviour:
- All outputs are registered. Reset values: busy = 0, comp_reset_n = 0, comp_index = 0, comp_block_num = 0, all sizes = 0, size_overflow = 0, slice_done = 0, timeout_err = 0.
- The component pipeline is held in reset while the scheduler is IDLE.
- FSM states: IDLE, LAUNCH, RUN, NEXT, DONE.
- IDLE: on slice_start = 1:
  - latch the inputs;
  - clear sizes and size_overflow;
  - set comp_index = 0 and busy = 1;
  - go to LAUNCH. If slice_block_num = 0, go directly to DONE instead.
- LAUNCH:
  - comp_reset_n = 0 for exactly RESET_CYCLES cycles (down-counter);
  - comp_block_num = luma count for Y; for Cb/Cr it is the count shifted right by 1 if chroma_422, otherwise the full count;
  - then go to RUN, with comp_reset_n = 1 from the first RUN cycle.
- Zero-block component (e.g. 4:2:2 with one luma block): LAUNCH is skipped, its size is written as 0, and the FSM moves to NEXT.
- RUN: on comp_done = 1, capture comp_byte_count into the size register selected by comp_index. If the count exceeds SIZE_W bits, store all-ones and set size_overflow. Then go to NEXT.
- NEXT (1 cycle): comp_reset_n = 0. If comp_index = 2, go to DONE; otherwise increment comp_index and go to LAUNCH.
- DONE (1 cycle):
  - slice_size registers the sum;
  - slice_done = 1 for this cycle only;
  - next cycle: busy = 0, state = IDLE.
- Latency: slice_start sampled at edge t gives busy = 1 and comp_reset_n = 0 over cycles t+1 .. t+RESET_CYCLES, released at t+RESET_CYCLES+1. comp_done for Cr at edge d gives slice_done high during cycle d+2.
- Ignored inputs: slice_start while busy; comp_done outside RUN.
- comp_done already high on the first RUN cycle is accepted.
- Size outputs hold their values until the next accepted slice_start.
- Asserting reset_n mid-slice returns everything to reset values immediately; no partial slice_done is produced.

Optional Feature:
- Macro: SLICE_SCHED_WATCHDOG_EN.
- Defined: a RUN-cycle counter is cleared on each entry to RUN. If it reaches WATCHDOG_CYCLES without comp_done:
  - the current size is set to 0;
  - timeout_err = 1, sticky until the next accepted slice_start;
  - the FSM goes directly to DONE, so remaining components are not launched;
  - slice_done still pulses.
- Undefined: no counter; timeout_err is constant 0 and RUN waits indefinitely.

Decomposition:
- Shared package component_pkg holds:
  - state encoding constants;
  - COMP_Y / COMP_CB / COMP_CR index constants;
  - the default SIZE_W;
  - the chroma block-count helper function.
- Optional sub-module slice_sched_watchdog contains the counter and compare, instantiated only under the macro.
- Everything else stays in one module.

Test Plan:
- 4:4:4, block_num = 8, RESET_CYCLES = 2, comp_done after 600 cycles with counts 300/120/130 → comp_block_num 8/8/8; y/cb/cr = 300/120/130; slice_size = 550; one slice_done pulse; reset pulse exactly 2 cycles per component.
- 4:2:2, block_num = 16 → comp_block_num 16/8/8; then block_num = 1 → Cb/Cr skipped with sizes 0 and no chroma reset pulses; slice_done still asserted.
- slice_start re-pulsed mid-RUN and comp_done pulsed during LAUNCH → both ignored; sizes match the first slice only.
- comp_byte_count = 70000 for Y with SIZE_W = 16 → y_size = 0xFFFF, size_overflow = 1; cleared by the next slice_start.
- reset_n asserted during Cb RUN → all outputs at reset values the same cycle; a new slice afterwards completes normally.
- With SLICE_SCHED_WATCHDOG_EN, WATCHDOG_CYCLES = 64, comp_done withheld for Cb → timeout_err = 1, cb_size = 0, Cr not launched, slice_done pulses once.
